inst_fetch: RTL and testbench

//  Producer side of the decoder interface. Keeps the program counter and

---
 rtl/inst_fetch_pkg.sv | 24 ++
 rtl/inst_fetch_if.sv | 30 +++
 rtl/inst_fetch.sv | 92 +++++++++
 tb/tb_inst_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: fetch FSM state encoding, opcode field masks and the
// needs_data() helper. The decoder uses the same opcode constants.
package inst_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_HI,
    FETCH_LO,
    FETCH_DATA,
    READY
  } fetch_state_t;

  localparam logic [15:0] ONE_ARG_MASK = 16'hC000;
  localparam logic [15:0] ONE_ARG_VAL  = 16'h8000;
  localparam logic [15:0] SRC_MASK     = 16'h0600;
  localparam logic [15:0] SRC_DATA     = 16'h0200;

  // One-argument instruction whose source operand is the trailing data byte
  // (src field 0x0200 or 0x0300).
  function automatic logic needs_data(input logic [15:0] i);
    return ((i & ONE_ARG_MASK) == ONE_ARG_VAL) && ((i & SRC_MASK) == SRC_DATA);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: byte-wide program memory port plus the fetch -> decoder
// handshake.
//   master (fetch unit): drives mem_rd, mem_addr, inst, data, inst_valid, pc
//   slave (memory/decoder/execute side): drives mem_rdata, mem_ack,
//     inst_done, branch_en, branch_target
interface inst_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic [15:0]       inst;
  logic [7:0]        data;
  logic              inst_valid;
  logic              inst_done;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc;

  modport master (
    output mem_rd, mem_addr, inst, data, inst_valid, pc,
    input  mem_rdata, mem_ack, inst_done, branch_en, branch_target
  );

  modport slave (
    input  mem_rd, mem_addr, inst, data, inst_valid, pc,
    output mem_rdata, mem_ack, inst_done, branch_en, branch_target
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit. Keeps the PC, reads instruction bytes
// over an 8-bit memory port, assembles the 16-bit instruction and, for
// data-sourced operands, the trailing data byte, then presents them to the
// decoder with inst_valid until execute signals inst_done.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   run  - fetching allowed (sampled in IDLE and READY)
//   bus  - inst_fetch_if.master: mem_rd/mem_addr/mem_rdata/mem_ack,
//          inst/data/inst_valid, inst_done/branch_en/branch_target, pc
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  inst_fetch_if.master bus
);

  fetch_state_t      state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [15:0]       inst, inst_d;
  logic [7:0]        data, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      inst  <= '0;
      data  <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      inst  <= inst_d;
      data  <= data_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    inst_d  = inst;
    data_d  = data;
    case (state)
      IDLE: begin
        if (run) state_d = FETCH_HI;
      end
      FETCH_HI: begin
        if (bus.mem_ack) begin
          inst_d[15:8] = bus.mem_rdata;
          pc_d         = pc + ADDR_W'(1);
          state_d      = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (bus.mem_ack) begin
          inst_d[7:0] = bus.mem_rdata;
          pc_d        = pc + ADDR_W'(1);
          // Decide on the freshly completed word, not the stale register.
          state_d     = needs_data({inst[15:8], bus.mem_rdata}) ? FETCH_DATA : READY;
        end
      end
      FETCH_DATA: begin
        if (bus.mem_ack) begin
          data_d  = bus.mem_rdata;
          pc_d    = pc + ADDR_W'(1);
          state_d = READY;
        end
      end
      READY: begin
        if (bus.inst_done) begin
          if (bus.branch_en) pc_d = bus.branch_target;
          state_d = run ? FETCH_HI : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded straight from the state register so that reset drops the read
  // request in the same cycle and address/request stay put until ack.
  assign bus.mem_rd     = (state == FETCH_HI) || (state == FETCH_LO) || (state == FETCH_DATA);
  assign bus.mem_addr   = pc;
  assign bus.inst       = inst;
  assign bus.data       = data;
  assign bus.inst_valid = (state == READY);
  assign bus.pc         = pc;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst;
  logic run;

  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(16)) bus();

  inst_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .run (run),
    .bus (bus)
  );

  // Memory model: combinational read, ack after ack_delay wait cycles.
  logic [7:0]  mem [0:65535];
  int unsigned ack_delay = 0;
  int unsigned wait_cnt  = 0;

  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ack   = bus.mem_rd && (wait_cnt >= ack_delay);

  always @(posedge clk)
    wait_cnt <= (bus.mem_rd && !bus.mem_ack && !rst) ? wait_cnt + 1 : 0;

  // Log of completed read addresses.
  logic [15:0] rd_log [$];
  always @(posedge clk)
    if (bus.mem_rd && bus.mem_ack) rd_log.push_back(bus.mem_addr);

  // Request/address stability while a read is pending.
  logic        pend = 1'b0;
  logic [15:0] pend_addr = '0;
  int unsigned unstable = 0;
  always @(posedge clk) begin
    if (pend && !rst && (!bus.mem_rd || bus.mem_addr !== pend_addr)) unstable++;
    pend      <= bus.mem_rd && !bus.mem_ack && !rst;
    pend_addr <= bus.mem_addr;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (bus.inst_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    run = 1'b0;
    bus.inst_done = 1'b0;
    bus.branch_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    rst = 1'b1;
    run = 1'b0;
    bus.inst_done     = 1'b0;
    bus.branch_en     = 1'b0;
    bus.branch_target = 16'h0000;
    #2;
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
    chk("rst_valid",  32'(bus.inst_valid), 32'h0);
    chk("rst_pc",     32'(bus.pc), 32'h0000);
    chk("rst_inst",   32'(bus.inst), 32'h0000);
    chk("rst_data",   32'(bus.data), 32'h00);
    tick();
    tick();
    rst = 1'b0;

    // run=0 after reset: no reads
    repeat (3) tick();
    chk("idle_no_rd",    32'(bus.mem_rd), 32'h0);
    chk("idle_no_reads", 32'(rd_log.size()), 32'd0);

    // 2-byte instruction, zero-wait
    mem[0] = 8'h80; mem[1] = 8'h2A; mem[2] = 8'hFF;
    run = 1'b1;
    tick();
    chk("hi_rd",   32'(bus.mem_rd), 32'h1);
    chk("hi_addr", 32'(bus.mem_addr), 32'h0000);
    wait_valid(10, n);
    chk("lat2",     32'(n), 32'd2);
    chk("t1_inst",  32'(bus.inst), 32'h802A);
    chk("t1_pc",    32'(bus.pc), 32'h0002);
    chk("t1_reads", 32'(rd_log.size()), 32'd2);
    run = 1'b0;
    tick();
    tick();
    chk("t1_no_third", 32'(rd_log.size()), 32'd2);
    chk("t1_hold",     32'(bus.inst_valid), 32'h1);
    chk("t1_rd_off",   32'(bus.mem_rd), 32'h0);

    // inst_done with run=0 -> IDLE, no read until run=1
    bus.inst_done = 1'b1;
    tick();
    bus.inst_done = 1'b0;
    chk("done_valid_fall", 32'(bus.inst_valid), 32'h0);
    repeat (3) tick();
    chk("idle2_no_rd",    32'(bus.mem_rd), 32'h0);
    chk("idle2_no_reads", 32'(rd_log.size()), 32'd2);
    run = 1'b1;
    tick();
    chk("resume_rd",   32'(bus.mem_rd), 32'h1);
    chk("resume_addr", 32'(bus.mem_addr), 32'h0002);

    // 3-byte instructions (src 0x0200 and 0x0300)
    do_reset();
    mem[0] = 8'h82; mem[1] = 8'h00; mem[2] = 8'h55;
    base = rd_log.size();
    run = 1'b1;
    tick();
    wait_valid(10, n);
    chk("lat3",     32'(n), 32'd3);
    chk("t2_inst",  32'(bus.inst), 32'h8200);
    chk("t2_data",  32'(bus.data), 32'h55);
    chk("t2_pc",    32'(bus.pc), 32'h0003);
    chk("t2_reads", 32'(rd_log.size() - base), 32'd3);
    for (int i = 0; i < 3; i++)
      if (base + i < rd_log.size())
        chk("t2_rd_addr", 32'(rd_log[base + i]), 32'(i));

    mem[3] = 8'h83; mem[4] = 8'h00; mem[5] = 8'h66;
    bus.inst_done = 1'b1;
    tick();
    bus.inst_done = 1'b0;
    wait_valid(10, n);
    chk("lat3b",    32'(n), 32'd3);
    chk("t2b_inst", 32'(bus.inst), 32'h8300);
    chk("t2b_data", 32'(bus.data), 32'h66);
    chk("t2b_pc",   32'(bus.pc), 32'h0006);

    // 2-byte instruction leaves data untouched
    mem[6] = 8'hC0; mem[7] = 8'h10;
    bus.inst_done = 1'b1;
    tick();
    bus.inst_done = 1'b0;
    wait_valid(10, n);
    chk("t3_inst",      32'(bus.inst), 32'hC010);
    chk("t3_data_keep", 32'(bus.data), 32'h66);
    chk("t3_pc",        32'(bus.pc), 32'h0008);

    // branch_en without inst_done has no effect
    bus.branch_en     = 1'b1;
    bus.branch_target = 16'h0010;
    tick();
    bus.branch_en = 1'b0;
    chk("br_no_done_pc",    32'(bus.pc), 32'h0008);
    chk("br_no_done_valid", 32'(bus.inst_valid), 32'h1);

    // taken branch
    mem[16'h0010] = 8'hC0; mem[16'h0011] = 8'h10;
    bus.inst_done = 1'b1;
    bus.branch_en = 1'b1;
    tick();
    bus.inst_done = 1'b0;
    bus.branch_en = 1'b0;
    chk("br_rd",   32'(bus.mem_rd), 32'h1);
    chk("br_addr", 32'(bus.mem_addr), 32'h0010);
    wait_valid(10, n);
    chk("br_pc", 32'(bus.pc), 32'h0012);

    // not taken
    mem[16'h0012] = 8'hC0; mem[16'h0013] = 8'h11;
    bus.inst_done = 1'b1;
    tick();
    bus.inst_done = 1'b0;
    chk("nbr_addr", 32'(bus.mem_addr), 32'h0012);
    wait_valid(10, n);
    chk("nbr_inst", 32'(bus.inst), 32'hC011);

    // instruction straddling the PC wrap
    mem[16'hFFFF] = 8'hA1; mem[0] = 8'hB2;
    bus.inst_done     = 1'b1;
    bus.branch_en     = 1'b1;
    bus.branch_target = 16'hFFFF;
    tick();
    bus.inst_done = 1'b0;
    bus.branch_en = 1'b0;
    chk("wrap_addr", 32'(bus.mem_addr), 32'hFFFF);
    wait_valid(10, n);
    chk("wrap_lat",  32'(n), 32'd2);
    chk("wrap_inst", 32'(bus.inst), 32'hA1B2);
    chk("wrap_pc",   32'(bus.pc), 32'h0001);

    // 3-cycle wait per byte
    do_reset();
    ack_delay = 3;
    mem[0] = 8'h91; mem[1] = 8'h23;
    base = rd_log.size();
    run = 1'b1;
    tick();
    chk("slow_addr", 32'(bus.mem_addr), 32'h0000);
    wait_valid(30, n);
    chk("slow_lat",    32'(n), 32'd8);
    chk("slow_inst",   32'(bus.inst), 32'h9123);
    chk("slow_reads",  32'(rd_log.size() - base), 32'd2);
    chk("slow_stable", 32'(unstable), 32'd0);

    // reset during FETCH_LO
    do_reset();
    ack_delay = 2;
    mem[0] = 8'h80; mem[1] = 8'h2A;
    run = 1'b1;
    tick();
    repeat (3) tick();
    chk("lo_rd",      32'(bus.mem_rd), 32'h1);
    chk("lo_addr",    32'(bus.mem_addr), 32'h0001);
    chk("lo_partial", 32'(bus.inst), 32'h8000);
    rst = 1'b1;
    #1;
    chk("midrst_rd",    32'(bus.mem_rd), 32'h0);
    chk("midrst_valid", 32'(bus.inst_valid), 32'h0);
    chk("midrst_pc",    32'(bus.pc), 32'h0000);
    chk("midrst_inst",  32'(bus.inst), 32'h0000);
    tick();
    rst = 1'b0;
    tick();
    chk("restart_rd",   32'(bus.mem_rd), 32'h1);
    chk("restart_addr", 32'(bus.mem_addr), 32'h0000);
    wait_valid(30, n);
    chk("restart_lat",  32'(n), 32'd6);
    chk("restart_inst", 32'(bus.inst), 32'h802A);
    chk("restart_pc",   32'(bus.pc), 32'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
